lbm_step_scheduler: RTL and testbench

//  Sequences the LBM solver through whole time steps. Each step is a

---
 rtl/lbm_step_scheduler_pkg.sv | 20 ++
 rtl/lbm_step_scheduler_phase_watchdog.sv | 27 ++
 rtl/lbm_step_scheduler.sv | 120 ++++++++++++
 tb/tb_lbm_step_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lbm_step_scheduler_pkg.sv
// lbm_step_scheduler_pkg: shared scheduler definitions (state encoding, widths, watchdog limit).
package lbm_step_scheduler_pkg;

    localparam int STEP_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 8192;
    localparam int TO_W_DEF    = 14;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STREAM  = 3'd1,
        S_COLLIDE = 3'd2,
        S_SWAP    = 3'd3,
        S_HOLD    = 3'd4
    } state_e;

    function automatic logic is_phase(state_e s);
        return (s == S_STREAM) || (s == S_COLLIDE);
    endfunction

endpackage

// File: rtl/lbm_step_scheduler_phase_watchdog.sv
// lbm_step_scheduler_phase_watchdog: counts cycles spent in a solver phase and flags overrun.
module lbm_step_scheduler_phase_watchdog #(
    parameter int TIMEOUT = 8192,
    parameter int TO_W    = 14
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TO_W-1:0] cnt_q, cnt_d;

    // The clearing cycle is itself the first cycle of the phase, so restart at 1.
    always_comb begin
        cnt_d = clear_i ? TO_W'(1) : en_i ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired_o = en_i && !clear_i && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/lbm_step_scheduler.sv
// lbm_step_scheduler: sequences stream/collide/swap time steps, counts steps
// against a host target and grants host readback only at step boundaries.
module lbm_step_scheduler
    import lbm_step_scheduler_pkg::*;
#(
    parameter int STEP_W  = STEP_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              en_i,
    input  logic [STEP_W-1:0] step_target_i,
    input  logic              stream_done_i,
    input  logic              collide_done_i,
    input  logic              host_req_i,
    output logic              stream_go_o,
    output logic              collide_go_o,
    output logic              bank_sel_o,
    output logic              host_grant_o,
    output logic [STEP_W-1:0] steps_done_o,
    output logic              busy_o,
    output logic              run_done_o,
    output logic              fault_o
);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] target_q, target_d, steps_q, steps_d, steps_inc;
    logic              bank_q, bank_d, fault_q, fault_d;
    logic              sgo_q, sgo_d, cgo_q, cgo_d, rd_q, rd_d, grant_en_q;
    logic              expired;

    lbm_step_scheduler_phase_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (sgo_q | cgo_q),
        .en_i     (is_phase(state_q)),
        .expired_o(expired)
    );

    assign steps_inc = (&steps_q) ? steps_q : steps_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        steps_d  = steps_q;
        bank_d   = bank_q;
        fault_d  = fault_q;
        sgo_d    = 1'b0;
        cgo_d    = 1'b0;
        rd_d     = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                target_d = step_target_i;
                steps_d  = '0;
                fault_d  = 1'b0;
                rd_d     = (step_target_i == '0);
                sgo_d    = (step_target_i != '0);
                state_d  = (step_target_i == '0) ? S_IDLE : S_STREAM;
            end
            S_STREAM: begin
                fault_d = fault_q | expired;
                cgo_d   = !expired && stream_done_i;
                state_d = expired ? S_IDLE : stream_done_i ? S_COLLIDE : S_STREAM;
            end
            S_COLLIDE: begin
                fault_d = fault_q | expired;
                state_d = expired ? S_IDLE : collide_done_i ? S_SWAP : S_COLLIDE;
            end
            S_SWAP: begin
                bank_d  = !bank_q;
                steps_d = steps_inc;
                rd_d    = (steps_inc == target_q);
                sgo_d   = !rd_d && !host_req_i && en_i;
                state_d = rd_d ? S_IDLE : sgo_d ? S_STREAM : S_HOLD;
            end
            S_HOLD: begin
                sgo_d   = !host_req_i && en_i;
                state_d = sgo_d ? S_STREAM : S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            steps_q    <= '0;
            bank_q     <= 1'b0;
            fault_q    <= 1'b0;
            sgo_q      <= 1'b0;
            cgo_q      <= 1'b0;
            rd_q       <= 1'b0;
            grant_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            steps_q    <= steps_d;
            bank_q     <= bank_d;
            fault_q    <= fault_d;
            sgo_q      <= sgo_d;
            cgo_q      <= cgo_d;
            rd_q       <= rd_d;
            grant_en_q <= (state_d == S_IDLE) || (state_d == S_HOLD);
        end
    end

    // Grant is gated by a registered boundary flag so it never rises mid-phase.
    assign host_grant_o = grant_en_q & host_req_i;
    assign stream_go_o  = sgo_q;
    assign collide_go_o = cgo_q;
    assign bank_sel_o   = bank_q;
    assign steps_done_o = steps_q;
    assign busy_o       = (state_q != S_IDLE);
    assign run_done_o   = rd_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_lbm_step_scheduler.sv
// tb_lbm_step_scheduler: directed plus randomized checks of the step scheduler
// against a step-level model (go/done counts, step history, bank parity).
module tb_lbm_step_scheduler;

    localparam int TIMEOUT = 8192;

    logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, en_i = 1'b1, host_req_i = 1'b0;
    logic [31:0] step_target_i = '0;
    logic        stream_done_i, collide_done_i;
    logic        stream_go_o, collide_go_o, bank_sel_o, host_grant_o, busy_o, run_done_o, fault_o;
    logic [31:0] steps_done_o;

    logic s_pulse = 1'b0, c_pulse = 1'b0, spur_s = 1'b0;
    int   s_cnt = 0, c_cnt = 0, s_dly = 10, c_dly = 10;
    bit   suppress_c = 1'b0;

    int          tests = 0, fails = 0;
    int          n_sgo = 0, n_cgo = 0, n_rd = 0, sg0, cg0, rd0, h0;
    logic [31:0] last_steps = '0;
    int          hist_s[$];
    bit          hist_b[$];
    bit          mb = 1'b0;

    assign stream_done_i  = s_pulse | spur_s;
    assign collide_done_i = c_pulse;

    always #5 clk = ~clk;

    lbm_step_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .en_i          (en_i),
        .step_target_i (step_target_i),
        .stream_done_i (stream_done_i),
        .collide_done_i(collide_done_i),
        .host_req_i    (host_req_i),
        .stream_go_o   (stream_go_o),
        .collide_go_o  (collide_go_o),
        .bank_sel_o    (bank_sel_o),
        .host_grant_o  (host_grant_o),
        .steps_done_o  (steps_done_o),
        .busy_o        (busy_o),
        .run_done_o    (run_done_o),
        .fault_o       (fault_o)
    );

    // Solver model: answer each go with a done pulse a set number of cycles later.
    initial forever begin
        @(negedge clk);
        s_pulse = (s_cnt == 1);
        c_pulse = (c_cnt == 1) && !suppress_c;
        if (s_cnt > 0) s_cnt--;
        if (c_cnt > 0) c_cnt--;
        if (stream_go_o) s_cnt = s_dly;
        if (collide_go_o) c_cnt = c_dly;
        if (!rst_n) begin s_cnt = 0; c_cnt = 0; end
    end

    initial forever begin
        @(negedge clk);
        n_sgo += int'(stream_go_o);
        n_cgo += int'(collide_go_o);
        n_rd  += int'(run_done_o);
        if (steps_done_o != last_steps && steps_done_o != 0) begin
            hist_s.push_back(int'(steps_done_o));
            hist_b.push_back(bank_sel_o);
        end
        last_steps = steps_done_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        #1;
        sg0 = n_sgo; cg0 = n_cgo; rd0 = n_rd; h0 = hist_s.size();
    endtask

    task automatic pulse_start(input int t);
        step_target_i = t;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_until(input string tag, input int which);
        int n = 0;
        while (!((which == 0 && collide_go_o) || (which == 1 && steps_done_o == 1)) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait"}, n < 5000, 1);
    endtask

    task automatic wait_done(input string tag, input int tgt);
        int   n = 0;
        logic pb = 1'b1;
        while (!run_done_o && n < 20000) begin
            pb = busy_o;
            @(negedge clk);
            n++;
        end
        chk({tag, "_run_done"}, run_done_o, 1);
        chk({tag, "_steps"}, steps_done_o, tgt);
        chk({tag, "_busy_before"}, pb, 1);
        chk({tag, "_busy_after"}, busy_o, 0);
        chk({tag, "_fault"}, fault_o, 0);
        #1;
        chk({tag, "_n_stream_go"}, n_sgo - sg0, tgt);
        chk({tag, "_n_collide_go"}, n_cgo - cg0, tgt);
        chk({tag, "_n_run_done"}, n_rd - rd0, 1);
    endtask

    task automatic full_run(input string tag, input int tgt);
        snap();
        pulse_start(tgt);
        chk({tag, "_go_latency"}, stream_go_o, 1);
        wait_done(tag, tgt);
        for (int k = 1; k <= tgt; k++) begin
            chk($sformatf("%s_hist_steps%0d", tag, k), hist_s[h0 + k - 1], k);
            chk($sformatf("%s_hist_bank%0d", tag, k), hist_b[h0 + k - 1], (int'(mb) + k) % 2);
        end
        mb = mb ^ tgt[0];
        chk({tag, "_bank_end"}, bank_sel_o, mb);
    endtask

    initial begin
        int n;
        host_req_i = 1'b1;
        #12;
        chk("reset_outputs", {stream_go_o, collide_go_o, bank_sel_o, host_grant_o, steps_done_o,
                              busy_o, run_done_o, fault_o}, 0);
        host_req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        host_req_i = 1'b1;
        #1 chk("idle_grant", host_grant_o, 1);
        host_req_i = 1'b0;
        #1 chk("idle_grant_drop", host_grant_o, 0);
        @(negedge clk);

        full_run("basic3", 3);

        snap();
        pulse_start(0);
        chk("zero_run_done", run_done_o, 1);
        chk("zero_busy", busy_o, 0);
        chk("zero_no_go", stream_go_o, 0);
        @(negedge clk);
        chk("zero_run_done_drop", run_done_o, 0);
        chk("zero_busy_later", busy_o, 0);

        snap();
        pulse_start(4);
        repeat (3) @(negedge clk);
        host_req_i = 1'b1;
        @(negedge clk);
        chk("host_mid_phase_grant", host_grant_o, 0);
        wait_until("host", 1);
        chk("host_hold_grant", host_grant_o, 1);
        chk("host_hold_steps", steps_done_o, 1);
        repeat (3) @(negedge clk);
        chk("host_hold_still", host_grant_o, 1);
        chk("host_hold_busy", busy_o, 1);
        host_req_i = 1'b0;
        @(negedge clk);
        chk("host_release_go", stream_go_o, 1);
        chk("host_release_grant", host_grant_o, 0);
        wait_done("host", 4);

        snap();
        suppress_c = 1'b1;
        pulse_start(2);
        wait_until("wdog", 0);
        n = 0;
        while (!fault_o && n < TIMEOUT + 10) begin
            @(negedge clk);
            n++;
        end
        chk("wdog_latency", n, TIMEOUT);
        chk("wdog_fault", fault_o, 1);
        chk("wdog_busy", busy_o, 0);
        chk("wdog_steps", steps_done_o, 0);
        suppress_c = 1'b0;
        repeat (3) @(negedge clk);
        chk("wdog_sticky", fault_o, 1);
        full_run("after_fault", 1);

        snap();
        pulse_start(5);
        wait_until("rst_step1", 1);
        wait_until("rst_collide2", 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrun_reset_outputs", {stream_go_o, collide_go_o, bank_sel_o, host_grant_o,
                                        steps_done_o, busy_o, run_done_o, fault_o}, 0);
        mb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        full_run("after_reset", 2);

        snap();
        pulse_start(3);
        wait_until("spur", 0);
        repeat (2) @(negedge clk);
        spur_s = 1'b1;
        step_target_i = 1;
        start_i = 1'b1;
        @(negedge clk);
        spur_s = 1'b0;
        start_i = 1'b0;
        en_i = 1'b0;
        @(negedge clk);
        #1 chk("spur_no_extra_collide", n_cgo - cg0, 1);
        chk("spur_busy", busy_o, 1);
        wait_until("pause", 1);
        repeat (4) @(negedge clk);
        chk("pause_steps", steps_done_o, 1);
        chk("pause_no_go", stream_go_o, 0);
        chk("pause_busy", busy_o, 1);
        chk("pause_grant", host_grant_o, 0);
        en_i = 1'b1;
        @(negedge clk);
        chk("pause_resume_go", stream_go_o, 1);
        wait_done("spur", 3);
        mb = mb ^ 1'b1;
        chk("spur_bank_end", bank_sel_o, mb);

        for (int i = 0; i < 5; i++) begin
            s_dly = $urandom_range(1, 12);
            c_dly = $urandom_range(1, 12);
            full_run($sformatf("rand%0d", i), $urandom_range(1, 6));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
